uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (fixed at 8 for this block).
REQ-002 Parameter OVERSAMPLE, default 16, number of sample ticks per bit period.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 baud_select  input  3  baud rate code, same encoding as the team's baud controller.
REQ-006 rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-007 rx_data  output  8  last received data byte.
REQ-008 rx_valid  output  1  one-cycle pulse: rx_data holds a good frame.
REQ-009 rx_perror  output  1  one-cycle pulse: parity mismatch on the completed frame.
REQ-010 rx_ferror  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 rx_busy  output  1  high from confirmed start bit until the frame ends.

Function
REQ-012 Internal sample-tick generator: limit per baud_select = 0:5208, 1:1302, 2:326, 3:163, 4:81, 5:41, 6:27, 7:14.
REQ-013 The tick counter runs 1..limit, emits a one-clk tick when it equals limit, then wraps to 1, giving period = limit clocks.
REQ-014 Tick counter width is 13 bits; baud_select is re-read every cycle, and a change takes effect at the next wrap.
REQ-015 rxd passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value only.
REQ-016 Frame format: start (0), 8 data bits LSB first, even parity bit, 1 stop bit (1).
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP; all advance only on tick cycles.
REQ-018 IDLE: a synchronized rxd low on a tick -> START, clear the sample counter.
REQ-019 START: at sample count 7 (mid-bit), rxd low -> DATA with counter cleared; rxd high -> IDLE (false start, no outputs).
REQ-020 DATA: sample rxd at every 16th tick (count 15), shift into a shift register MSB-in, and advance the bit index; after index 7 -> PARITY.
REQ-021 PARITY: sample at count 15, compute even parity = XOR of 8 data bits XOR sampled bit, then -> STOP.
REQ-022 STOP: sample at count 15, and on the same clk -> IDLE.
REQ-023 Stop sample high and parity good: rx_data <= shift register and rx_valid pulses on the next clk.
REQ-024 Stop sample low: rx_ferror pulses; rx_valid stays low; rx_data is not updated.
REQ-025 Parity bad and stop high: rx_perror pulses; rx_valid stays low; rx_data is not updated.
REQ-026 Parity bad and stop low: both error pulses fire together.
REQ-027 Each pulse output is high for exactly one clk per frame.
REQ-028 rx_busy is high in DATA, PARITY and STOP, and low in IDLE and START.
REQ-029 After STOP the receiver accepts a new start edge on the next tick; back-to-back frames are not lost.
REQ-030 A line held low (break) produces a frame with ferror, then waits in IDLE until rxd goes high before it re-arms.

Reset
REQ-031 reset high: FSM=IDLE, tick counter=0, sample counter=0, bit index=0, shift register=0, synchronizer=1.
REQ-032 reset high: rx_data=0x00, rx_valid=0, rx_perror=0, rx_ferror=0, rx_busy=0.
REQ-033 reset asserted mid-frame aborts the frame with no pulse output; the receiver resumes hunting for a start bit on the first tick after release.

Verification
REQ-034 baud_select=7 (bit time 224 clk); send 0x55 with parity 0 and stop 1 -> one rx_valid pulse, rx_data=0x55, no errors.
REQ-035 baud_select=7; send 0xA7 with parity 0 (wrong, expected 1) -> rx_perror pulse, rx_valid=0, rx_data keeps its previous value.
REQ-036 baud_select=6; send 0x3C with stop bit 0 -> rx_ferror pulse, rx_valid=0.
REQ-037 Low glitch on rxd of 3 ticks while idle -> no busy, no pulses, FSM returns to IDLE.
REQ-038 Two back-to-back frames 0x01 then 0xFE, no idle gap -> two rx_valid pulses with the correct data.
REQ-039 reset held 1 clk during data bit 4 -> all outputs 0 and no pulse; a following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits, even parity, 1 stop bit, 16x oversampling from an
// internal baud tick generator. Outputs are registered single-cycle status pulses.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           baud_select,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_perror,
  output logic                 rx_ferror,
  output logic                 rx_busy,
  output logic [2:0]           fsm_state
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [12:0]           tick_cnt, cur_limit, sel_limit;
  logic                  tick;
  logic                  sync1, rxd_s;
  logic [SW-1:0]         samp, samp_n;
  logic [BW-1:0]         bit_idx, bit_n;
  logic [DATA_BITS-1:0]  shift, shift_n, data_n;
  logic                  par_bad, par_bad_n;
  logic                  brk, brk_n;
  logic                  valid_n, perr_n, ferr_n;

  always_comb begin
    case (baud_select)
      3'd0:    sel_limit = 13'd5208;
      3'd1:    sel_limit = 13'd1302;
      3'd2:    sel_limit = 13'd326;
      3'd3:    sel_limit = 13'd163;
      3'd4:    sel_limit = 13'd81;
      3'd5:    sel_limit = 13'd41;
      3'd6:    sel_limit = 13'd27;
      default: sel_limit = 13'd14;
    endcase
  end

  // The limit is latched at each wrap so a baud change never truncates a period.
  assign tick = (tick_cnt == cur_limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= 13'd0;
      cur_limit <= sel_limit;
    end else if (tick) begin
      tick_cnt  <= 13'd1;
      cur_limit <= sel_limit;
    end else begin
      tick_cnt  <= tick_cnt + 13'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      samp      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      par_bad   <= 1'b0;
      brk       <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_perror <= 1'b0;
      rx_ferror <= 1'b0;
    end else begin
      state     <= state_n;
      samp      <= samp_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      par_bad   <= par_bad_n;
      brk       <= brk_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      rx_perror <= perr_n;
      rx_ferror <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    samp_n    = samp;
    bit_n     = bit_idx;
    shift_n   = shift;
    par_bad_n = par_bad;
    brk_n     = brk;
    data_n    = rx_data;
    valid_n   = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    // A frame that ended with a low stop bit stays disarmed until the line returns high.
    if (rxd_s) brk_n = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rxd_s && !brk) begin
            state_n = START;
            samp_n  = '0;
          end
        end
        START: begin
          if (samp == SAMP_MID) begin
            samp_n  = '0;
            bit_n   = '0;
            state_n = rxd_s ? IDLE : DATA;
          end else begin
            samp_n = samp + 1'b1;
          end
        end
        DATA: begin
          if (samp == SAMP_LAST) begin
            samp_n  = '0;
            shift_n = {rxd_s, shift[DATA_BITS-1:1]};
            bit_n   = bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) state_n = PARITY;
          end else begin
            samp_n = samp + 1'b1;
          end
        end
        PARITY: begin
          if (samp == SAMP_LAST) begin
            samp_n    = '0;
            par_bad_n = (^shift) ^ rxd_s;
            state_n   = STOP;
          end else begin
            samp_n = samp + 1'b1;
          end
        end
        STOP: begin
          if (samp == SAMP_LAST) begin
            samp_n  = '0;
            state_n = IDLE;
            perr_n  = par_bad;
            ferr_n  = !rxd_s;
            brk_n   = !rxd_s;
            if (rxd_s && !par_bad) begin
              data_n  = shift;
              valid_n = 1'b1;
            end
          end else begin
            samp_n = samp + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign rx_busy   = (state == DATA) || (state == PARITY) || (state == STOP);
  assign fsm_state = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames against a frame-level reference model:
// the expected outcome of each frame is derived from its data, parity and stop bits.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid, rx_perror, rx_ferror, rx_busy;
  logic [2:0] fsm_state;

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_perror(rx_perror),
    .rx_ferror(rx_ferror), .rx_busy(rx_busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int bit_clks;
  int v_cnt = 0, p_cnt = 0, f_cnt = 0;
  int exp_v = 0, exp_p = 0, exp_f = 0;
  logic [7:0] exp_data;
  logic busy_seen;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Every high cycle is counted, so a pulse wider than one clk shows up as an extra count.
  always @(negedge clk) begin
    if (rx_valid) begin
      v_cnt++;
      got_q.push_back(rx_data);
    end
    if (rx_perror) p_cnt++;
    if (rx_ferror) f_cnt++;
    if (rx_busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is good when its 9 bits have even parity and its stop bit is 1.
  task automatic expect_frame(input logic [7:0] d, input logic pbit, input logic stopb);
    logic par_ok;
    par_ok = ((^d) ^ pbit) == 1'b0;
    if (!par_ok) exp_p++;
    if (!stopb) exp_f++;
    if (par_ok && stopb) begin
      exp_v++;
      exp_q.push_back(d);
      exp_data = d;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb);
    logic [10:0] f;
    f = {stopb, pbit, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      rxd = f[i];
      repeat (bit_clks - 1) @(posedge clk);
    end
    @(posedge clk);
    rxd = 1'b1;
  endtask

  task automatic check_all(input string tag);
    repeat (bit_clks / 4) @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_cnt"}, v_cnt, exp_v);
    check({tag, "_perr_cnt"}, p_cnt, exp_p);
    check({tag, "_ferr_cnt"}, f_cnt, exp_f);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (got_q.size() == 0) check({tag, "_missing_byte"}, 32'hffff_ffff, e);
      else check({tag, "_byte"}, got_q.pop_front(), e);
    end
    check({tag, "_rx_data"}, rx_data, exp_data);
  endtask

  task automatic set_baud(input logic [2:0] bs, input int lim);
    baud_select = bs;
    bit_clks = 16 * lim;
    repeat (bit_clks) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rxd = 1'b1;
    baud_select = 3'd7;
    bit_clks = 16 * 14;
    exp_data = 8'h00;
    busy_seen = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_perror", rx_perror, 1'b0);
    check("rst_ferror", rx_ferror, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_state", fsm_state, 3'd0);
    reset = 1'b0;
    repeat (bit_clks) @(posedge clk);

    expect_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    check_all("good_55");

    expect_frame(8'hA7, 1'b0, 1'b1);
    send_frame(8'hA7, 1'b0, 1'b1);
    check_all("perr_A7");

    set_baud(3'd6, 27);
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    check_all("ferr_3C");
    set_baud(3'd7, 14);

    busy_seen = 1'b0;
    @(posedge clk);
    rxd = 1'b0;
    repeat (3 * 14) @(posedge clk);
    rxd = 1'b1;
    repeat (20 * 14) @(posedge clk);
    @(negedge clk);
    check("glitch_busy", busy_seen, 1'b0);
    check("glitch_state", fsm_state, 3'd0);
    check_all("glitch");

    expect_frame(8'h01, 1'b1, 1'b1);
    expect_frame(8'hFE, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFE, 1'b1, 1'b1);
    check_all("b2b");

    // Break: the line stays low far beyond a frame, so exactly one framing error is expected.
    expect_frame(8'h00, 1'b0, 1'b0);
    @(posedge clk);
    rxd = 1'b0;
    repeat (20 * bit_clks) @(posedge clk);
    rxd = 1'b1;
    repeat (2 * bit_clks) @(posedge clk);
    check_all("break");

    // Abort a frame halfway through data bit 4 with a one-clk reset.
    @(posedge clk);
    rxd = 1'b0;
    repeat (bit_clks) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      repeat (bit_clks) @(posedge clk);
    end
    rxd = 1'b1;
    repeat (bit_clks / 2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_valid", rx_valid, 1'b0);
    check("mid_rst_busy", rx_busy, 1'b0);
    check("mid_rst_state", fsm_state, 3'd0);
    exp_data = 8'h00;
    repeat (12 * bit_clks) @(posedge clk);
    check_all("mid_rst_quiet");
    expect_frame(8'h81, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);
    check_all("after_rst_81");

    for (int n = 0; n < 8; n++) begin
      logic [7:0] d;
      logic pb, sb;
      d  = 8'($urandom_range(0, 255));
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 4) != 0);
      expect_frame(d, pb, sb);
      send_frame(d, pb, sb);
      check_all("rand");
    end

    check("extra_bytes", got_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
